mult_div_unit: RTL and testbench

- Iterative MIPS HI/LO multiply/divide unit sitting directly downstream of the register file.
- Consumes readData1/readData2 as operands for MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Holds the architectural HI/LO registers; results are read by the MFHI/MFLO path.
- The decode/control stage stalls on busy.

---
 rtl/mdu_pkg.sv | 16 +
 rtl/mdu_sign_fix.sv | 40 ++++
 rtl/mult_div_unit.sv | 186 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit.
// Op codes, FSM state type and iteration count.
package mdu_pkg;

   localparam int unsigned ITER_COUNT = 32;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign helpers: operand absolute values on entry and result
// negation on exit (64-bit for products, per-half for quotient/remainder).
module mdu_sign_fix #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] a_abs,
   output logic [WIDTH-1:0] b_abs,
   output logic             a_neg,
   output logic             b_neg,
   input  logic             wide,
   input  logic             neg_hi,
   input  logic             neg_lo,
   input  logic [WIDTH-1:0] res_hi,
   input  logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] fix_hi,
   output logic [WIDTH-1:0] fix_lo
);

   logic [2*WIDTH-1:0] wide_neg;

   always_comb begin
      a_neg = is_signed & a_in[WIDTH-1];
      b_neg = is_signed & b_in[WIDTH-1];
      a_abs = a_neg ? -a_in : a_in;
      b_abs = b_neg ? -b_in : b_in;

      wide_neg = -{res_hi, res_lo};
      if (wide) begin
         // Product negation must carry across the HI/LO boundary.
         {fix_hi, fix_lo} = neg_lo ? wide_neg : {res_hi, res_lo};
      end else begin
         fix_hi = neg_hi ? -res_hi : res_hi;
         fix_lo = neg_lo ? -res_lo : res_lo;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: shift-add multiply, restoring
// divide, fixed 33-cycle latency, MTHI/MTLO single-cycle writes.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   output logic             busy,
   output logic             done,
   output logic             divZero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = $clog2(ITER_COUNT);
   localparam logic [CntW-1:0] LastCnt = CntW'(ITER_COUNT - 1);

   mdu_state_e state_q, state_d;

   logic [2*WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               kind_mul_q, kind_mul_d;
   logic               neg_hi_q, neg_hi_d, neg_lo_q, neg_lo_d;
   logic               div_zero_q, div_zero_d;
   logic               done_q, done_d;

   logic               accept, op_mul, op_div, op_signed;
   logic [WIDTH-1:0]   a_abs, b_abs, fix_hi, fix_lo;
   logic               a_neg, b_neg;
   logic [WIDTH:0]     mul_sum, rem_shift, rem_diff;
   logic               fits;
   logic [2*WIDTH-1:0] mul_next, div_next;

   assign accept    = start && (state_q == IDLE);
   assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
   assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
   assign op_signed = (op == OP_MULT) || (op == OP_DIV);

   mdu_sign_fix #(
      .WIDTH(WIDTH)
   ) u_sign_fix (
      .is_signed(op_signed),
      .a_in     (operandA),
      .b_in     (operandB),
      .a_abs    (a_abs),
      .b_abs    (b_abs),
      .a_neg    (a_neg),
      .b_neg    (b_neg),
      .wide     (kind_mul_q),
      .neg_hi   (neg_hi_q),
      .neg_lo   (neg_lo_q),
      .res_hi   (work_q[2*WIDTH-1:WIDTH]),
      .res_lo   (work_q[WIDTH-1:0]),
      .fix_hi   (fix_hi),
      .fix_lo   (fix_lo)
   );

   // One iteration step of each algorithm; work_q holds {upper, lower} halves.
   always_comb begin
      mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, mcand_q} : '0);
      mul_next  = {mul_sum, work_q[WIDTH-1:1]};
      rem_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
      fits      = rem_shift >= {1'b0, mcand_q};
      rem_diff  = rem_shift - {1'b0, mcand_q};
      div_next  = {fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0],
                   work_q[WIDTH-2:0], fits};
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept && op_mul) begin
               state_d = MUL;
            end else if (accept && op_div) begin
               state_d = DIV;
            end
         end
         MUL, DIV: begin
            if (cnt_q == LastCnt) begin
               state_d = FIX;
            end
         end
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q != IDLE);
      done    = done_q;
      divZero = div_zero_q;
      hi      = hi_q;
      lo      = lo_q;
   end

   always_comb begin
      work_d     = work_q;
      mcand_d    = mcand_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      cnt_d      = cnt_q;
      kind_mul_d = kind_mul_q;
      neg_hi_d   = neg_hi_q;
      neg_lo_d   = neg_lo_q;
      div_zero_d = div_zero_q;
      done_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept && (op_mul || op_div)) begin
               kind_mul_d = op_mul;
               mcand_d    = op_mul ? a_abs : b_abs;
               work_d     = {{WIDTH{1'b0}}, op_mul ? b_abs : a_abs};
               neg_lo_d   = a_neg ^ b_neg;
               // Remainder follows the dividend's sign.
               neg_hi_d   = op_mul ? (a_neg ^ b_neg) : a_neg;
               cnt_d      = '0;
               div_zero_d = 1'b0;
            end else if (accept && (op == OP_MTHI)) begin
               hi_d = operandA;
            end else if (accept && (op == OP_MTLO)) begin
               lo_d = operandA;
            end
         end
         MUL: begin
            work_d = mul_next;
            cnt_d  = cnt_q + CntW'(1);
         end
         DIV: begin
            work_d = div_next;
            cnt_d  = cnt_q + CntW'(1);
         end
         FIX: begin
            // A zero divisor leaves |dividend| in the remainder, so HI restores it.
            div_zero_d = !kind_mul_q && (mcand_q == '0);
            hi_d       = fix_hi;
            lo_d       = div_zero_d ? '1 : fix_lo;
            done_d     = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         work_q     <= '0;
         mcand_q    <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         cnt_q      <= '0;
         kind_mul_q <= 1'b0;
         neg_hi_q   <= 1'b0;
         neg_lo_q   <= 1'b0;
         div_zero_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         work_q     <= work_d;
         mcand_q    <= mcand_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         cnt_q      <= cnt_d;
         kind_mul_q <= kind_mul_d;
         neg_hi_q   <= neg_hi_d;
         neg_lo_q   <= neg_lo_d;
         div_zero_q <= div_zero_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table with scoreboard plus
// hand-written sequences for busy-ignore, mid-operation reset and MTHI.
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] operandA = '0;
   logic [31:0] operandB = '0;
   logic        busy, done, divZero;
   logic [31:0] hi, lo;

   always #5 clk = ~clk;

   mult_div_unit #(
      .WIDTH(32)
   ) dut (
      .clk     (clk),
      .resetN  (resetN),
      .start   (start),
      .op      (op),
      .operandA(operandA),
      .operandB(operandB),
      .busy    (busy),
      .done    (done),
      .divZero (divZero),
      .hi      (hi),
      .lo      (lo)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] h, input logic [31:0] l, input logic dz);
      vec_t v;
      v.op = o; v.a = a; v.b = b; v.hi = h; v.lo = l; v.dz = dz;
      return v;
   endfunction

   // Reference arithmetic using the simulator's own operators.
   function automatic vec_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      vec_t v;
      logic [63:0] p;
      v = mk(o, a, b, '0, '0, 1'b0);
      if (o == OP_MULT) begin
         p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         v.hi = p[63:32]; v.lo = p[31:0];
      end else if (o == OP_MULTU) begin
         p = {32'b0, a} * {32'b0, b};
         v.hi = p[63:32]; v.lo = p[31:0];
      end else if (b == 32'd0) begin
         v.hi = a; v.lo = 32'hFFFF_FFFF; v.dz = 1'b1;
      end else if (o == OP_DIV) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            v.hi = 32'd0; v.lo = 32'h8000_0000;
         end else begin
            v.lo = $signed(a) / $signed(b);
            v.hi = $signed(a) % $signed(b);
         end
      end else begin
         v.lo = a / b;
         v.hi = a % b;
      end
      return v;
   endfunction

   task automatic run_op(input vec_t v, input string tag);
      exp_t        e;
      int          n;
      logic [31:0] hi0, lo0;
      bit          busy_ok;
      hi0 = hi;
      lo0 = lo;
      op = v.op; operandA = v.a; operandB = v.b; start = 1'b1;
      e.hi = v.hi; e.lo = v.lo; e.dz = v.dz;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      operandA = $urandom;
      operandB = $urandom;
      n = 0;
      busy_ok = 1'b1;
      while (n < 40 && !done) begin
         if (!busy) busy_ok = 1'b0;
         if (n == 16) begin
            check({tag, ".hi_hold"}, hi, hi0);
            check({tag, ".lo_hold"}, lo, lo0);
         end
         @(posedge clk); #1;
         n++;
      end
      check({tag, ".latency"}, 32'(n), 32'd33);
      check({tag, ".busy_high"}, {31'd0, busy_ok}, 32'd1);
      check({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
         check({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, ".hi"}, hi, e.hi);
         check({tag, ".lo"}, lo, e.lo);
         check({tag, ".divZero"}, {31'd0, divZero}, {31'd0, e.dz});
      end
   endtask

   task automatic pulse_op(input logic [2:0] o, input logic [31:0] a);
      op = o; operandA = a; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs.push_back(mk(OP_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0));
      vecs.push_back(mk(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0));
      vecs.push_back(mk(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0));
      vecs.push_back(mk(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0));
      vecs.push_back(mk(OP_DIVU,  32'd100,        32'd7,         32'd2,         32'd14,        0));
      vecs.push_back(mk(OP_DIV,   32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0));
      vecs.push_back(mk(OP_DIV,   32'hFFFF_FFF6, 32'd0,         32'hFFFF_FFF6, 32'hFFFF_FFFF, 1));
      vecs.push_back(mk(OP_MULT,  32'd0,          32'd12345,     32'd0,         32'd0,         0));
      vecs.push_back(mk(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0));
      for (int i = 0; i < 6; i++) begin
         vecs.push_back(model(3'($urandom_range(0, 3)), $urandom,
                              (i % 2 == 0) ? $urandom : $urandom_range(1, 20)));
      end

      #12;
      check("reset.busy", {31'd0, busy}, 32'd0);
      check("reset.done", {31'd0, done}, 32'd0);
      check("reset.divZero", {31'd0, divZero}, 32'd0);
      check("reset.hi", hi, 32'd0);
      check("reset.lo", lo, 32'd0);
      @(negedge clk);
      resetN = 1'b1;
      @(posedge clk); #1;

      // Each op is issued in the previous op's done cycle.
      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i], $sformatf("vec%0d", i));
      end

      run_op(mk(OP_DIVU, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF, 1), "divu_zero");
      pulse_op(OP_MTHI, 32'd5);
      check("mthi.hi", hi, 32'd5);
      check("mthi.busy", {31'd0, busy}, 32'd0);
      check("mthi.done", {31'd0, done}, 32'd0);
      check("mthi.divZero", {31'd0, divZero}, 32'd1);
      pulse_op(3'd6, 32'hDEAD_BEEF);
      check("op6.hi", hi, 32'd5);
      check("op6.lo", lo, 32'hFFFF_FFFF);
      check("op6.busy", {31'd0, busy}, 32'd0);

      pulse_op(OP_MTHI, 32'h11);
      pulse_op(OP_MTLO, 32'h11);
      op = OP_MULT; operandA = 32'd3; operandB = 32'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (n < 40 && !done) begin
         @(posedge clk); #1;
         n++;
         if (n == 5) begin
            op = OP_MTLO; operandA = 32'd9; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (n == 8) begin
            check("ignore.lo_busy", lo, 32'h11);
            check("ignore.hi_busy", hi, 32'h11);
         end
      end
      start = 1'b0;
      check("ignore.latency", 32'(n), 32'd33);
      check("ignore.lo", lo, 32'd12);
      check("ignore.hi", hi, 32'd0);

      op = OP_MULT; operandA = 32'd3; operandB = 32'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
      end
      resetN = 1'b0;
      #1;
      check("abort.busy", {31'd0, busy}, 32'd0);
      check("abort.hi", hi, 32'd0);
      check("abort.lo", lo, 32'd0);
      check("abort.done", {31'd0, done}, 32'd0);
      @(negedge clk);
      resetN = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("abort.idle", {31'd0, busy}, 32'd0);
      check("abort.lo_held", lo, 32'd0);
      run_op(mk(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 0), "after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
